// File: rtl/sigmoid_out_packer.sv
// Quantizes Q16.16 sigmoid results to 8-bit codes, packs LANES codes per word and buffers them in a small FIFO.
// Optional macro SIGMOID_PACK_SAT_COUNT_EN adds a saturation counter output (sat_count).
module sigmoid_out_packer #(
  parameter int BIT_WIDTH     = 32,
  parameter int DECIMAL_WIDTH = 16,
  parameter int SIG_LATENCY   = 4,
  parameter int LANES         = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic                 flush,
  input  logic [BIT_WIDTH-1:0] act_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic                 out_last,
  output logic                 idle
`ifdef SIGMOID_PACK_SAT_COUNT_EN
  ,
  output logic [15:0]          sat_count
`endif
);

  localparam int WORD_W = 8 * LANES;
  localparam int LCW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W  = $clog2(SIG_LATENCY + 1);
  localparam int CW     = 16;

  logic [SIG_LATENCY-1:0] vld_dly_reg;
  logic [WORD_W-1:0]      pack_reg;
  logic [WORD_W-1:0]      pack_next;
  logic [LCW-1:0]         lane_cnt_reg;
  logic                   flush_pending_reg;
  logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]       fifo_cnt_reg;
  logic [WORD_W:0]        fifo_mem [FIFO_DEPTH];

  logic              land_valid, accept;
  logic [INF_W-1:0]  inflight;
  logic              int_hit;
  logic [8:0]        rnd_sum;
  logic [7:0]        code;
  logic              word_done, flush_ready, flush_fire, push, pop, push_last;
  logic [WORD_W-1:0] push_data;
  logic [CW-1:0]     cap, used;

  assign land_valid = vld_dly_reg[SIG_LATENCY-1];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < SIG_LATENCY; i++) begin
      inflight = inflight + INF_W'(vld_dly_reg[i]);
    end
  end

  // Round half up on the bit just below the kept byte; any integer bit means 1.0 -> 0xFF.
  assign int_hit = |act_in[BIT_WIDTH-1:DECIMAL_WIDTH];
  assign rnd_sum = {1'b0, act_in[DECIMAL_WIDTH-1:DECIMAL_WIDTH-8]} + 9'(act_in[DECIMAL_WIDTH-9]);
  assign code    = (int_hit || rnd_sum[8]) ? 8'hFF : rnd_sum[7:0];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign pack_next[8*gi +: 8] = (land_valid && lane_cnt_reg == LCW'(gi)) ? code : pack_reg[8*gi +: 8];
    end
  endgenerate

  assign word_done   = land_valid && (lane_cnt_reg == LCW'(LANES - 1));
  assign flush_ready = flush_pending_reg && (inflight == '0);
  assign flush_fire  = flush_ready && (lane_cnt_reg != '0);
  assign push        = word_done || flush_fire;
  assign push_data   = word_done ? pack_next : pack_reg;
  assign push_last   = flush_fire;
  assign pop         = out_valid && out_ready;

  // Credits: every element already issued has a reserved slot, so landing never overflows.
  assign cap         = (CW'(FIFO_DEPTH) - CW'(fifo_cnt_reg)) * CW'(LANES);
  assign used        = CW'(lane_cnt_reg) + CW'(inflight);
  assign issue_ready = (cap > used) && !flush_pending_reg;
  assign accept      = issue_valid && issue_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_dly_reg       <= '0;
      pack_reg          <= '0;
      lane_cnt_reg      <= '0;
      flush_pending_reg <= 1'b0;
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      fifo_cnt_reg      <= '0;
    end else begin
      vld_dly_reg <= (vld_dly_reg << 1) | SIG_LATENCY'(accept);
      if (push) begin
        pack_reg     <= '0;
        lane_cnt_reg <= '0;
      end else if (land_valid) begin
        pack_reg     <= pack_next;
        lane_cnt_reg <= lane_cnt_reg + LCW'(1);
      end
      if (flush_ready) begin
        flush_pending_reg <= 1'b0;
      end else if (flush) begin
        flush_pending_reg <= 1'b1;
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + CNT_W'(1);
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - CNT_W'(1);
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {push_last, push_data};
  end

  // Head is gated by valid so stale storage never shows after reset or drain.
  assign out_valid = (fifo_cnt_reg != '0);
  assign out_data  = out_valid ? fifo_mem[rd_ptr_reg][WORD_W-1:0] : '0;
  assign out_last  = out_valid ? fifo_mem[rd_ptr_reg][WORD_W] : 1'b0;
  assign idle      = (inflight == '0) && (lane_cnt_reg == '0) && (fifo_cnt_reg == '0) && !flush_pending_reg;

`ifdef SIGMOID_PACK_SAT_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_count <= '0;
    end else if (land_valid && (int_hit || rnd_sum[8]) && sat_count != 16'hFFFF) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sigmoid_out_packer.sv
// Randomized and directed bench for sigmoid_out_packer against a queue-based element/word model.
module tb_sigmoid_out_packer;
  localparam int L     = 4;
  localparam int LANES = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_ready, flush, out_valid, out_ready, out_last, idle;
  logic [31:0] act_in;
  logic [31:0] out_data;
`ifdef SIGMOID_PACK_SAT_COUNT_EN
  logic [15:0] sat_count;
`endif

  sigmoid_out_packer dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .flush(flush), .act_in(act_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .idle(idle)
`ifdef SIGMOID_PACK_SAT_COUNT_EN
    , .sat_count(sat_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int land; logic [31:0] val; } elem_t;
  typedef struct { logic [31:0] data; logic last; } word_t;

  elem_t      infl_q[$];
  logic [7:0] part_q[$];
  word_t      fifo_q[$];
  bit         fpend;
  int         cyc;
  int         errors = 0;
  int         checks = 0;
  int         dut_acc;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference quantizer: floor(v/256 + 1/2) clamped to 255; 1.0 and above maps to 255.
  function automatic logic [7:0] quant(input logic [31:0] v);
    int unsigned c;
    if (v >= 32'h0001_0000) return 8'hFF;
    c = (v + 128) / 256;
    return (c > 255) ? 8'hFF : 8'(c);
  endfunction

  function automatic bit model_ready();
    int free;
    free = (DEPTH - int'(fifo_q.size())) * LANES - int'(part_q.size()) - int'(infl_q.size());
    return (free >= 1) && !fpend;
  endfunction

  function automatic logic [31:0] part_word();
    logic [31:0] w = '0;
    foreach (part_q[i]) w[8*i +: 8] = part_q[i];
    return w;
  endfunction

  function automatic logic [31:0] gen_val();
    case ($urandom_range(0, 4))
      0:       return 32'($urandom_range(0, 32'h0001_0000));
      1:       return 32'h0000_FF00 + 32'($urandom_range(0, 255));
      2:       return {1'b0, 31'($urandom)};
      3:       return 32'($urandom_range(0, 511));
      default: return 32'($urandom_range(0, 32'h0000_FFFF));
    endcase
  endfunction

  task automatic model_clear();
    infl_q.delete(); part_q.delete(); fifo_q.delete(); fpend = 0;
  endtask

  task automatic model_step(input bit iv, input bit fl, input bit ordy, input logic [31:0] val);
    bit    rdy, do_pop, landing, fl_fire;
    int    inf_pre;
    elem_t e;
    word_t w;
    inf_pre = infl_q.size();
    rdy     = model_ready();
    do_pop  = (fifo_q.size() > 0) && ordy;
    landing = (inf_pre > 0) && (infl_q[0].land == cyc);
    fl_fire = fpend && (inf_pre == 0);
    if (do_pop) begin
      w = fifo_q.pop_front();
      $display("word data=%08h last=%0b", w.data, w.last);
    end
    if (landing) begin
      e = infl_q.pop_front();
      part_q.push_back(quant(e.val));
      if (part_q.size() == LANES) begin
        fifo_q.push_back('{part_word(), 1'b0});
        part_q.delete();
      end
    end
    if (fl_fire) begin
      if (part_q.size() > 0) fifo_q.push_back('{part_word(), 1'b1});
      part_q.delete();
      fpend = 0;
    end else if (fl) begin
      fpend = 1;
    end
    if (iv && rdy) infl_q.push_back('{cyc + L, val});
    cyc++;
  endtask

  task automatic check_outputs();
    check_val("issue_ready", issue_ready, model_ready());
    check_val("out_valid", out_valid, fifo_q.size() > 0);
    check_val("idle", idle, (infl_q.size() == 0) && (part_q.size() == 0) && (fifo_q.size() == 0) && !fpend);
    if (fifo_q.size() > 0) begin
      check_val("out_data", out_data, fifo_q[0].data);
      check_val("out_last", out_last, fifo_q[0].last);
    end
  endtask

  // Called at a falling edge: drive one cycle of inputs, advance the model, check after the next falling edge.
  task automatic tick(input bit iv, input bit fl, input bit ordy, input logic [31:0] val);
    issue_valid = iv;
    flush       = fl;
    out_ready   = ordy;
    act_in      = (infl_q.size() > 0 && infl_q[0].land == cyc) ? infl_q[0].val : $urandom;
    if (iv && issue_ready) dut_acc++;
    model_step(iv, fl, ordy, val);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_valid(input int max_cyc);
    int n = 0;
    while (!out_valid && n < max_cyc) begin
      tick(0, 0, 0, 32'h0);
      n++;
    end
    if (!out_valid) check_val("wait_valid_tmo", out_valid, 1'b1);
  endtask

  initial begin
    reset = 1'b0; issue_valid = 0; flush = 0; out_ready = 0; act_in = '0;
    cyc = 0; dut_acc = 0; model_clear();
    #1;
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_out_last", out_last, 1'b0);
    check_val("rst_out_data", out_data, 32'h0);
    check_val("rst_issue_ready", issue_ready, 1'b1);
    check_val("rst_idle", idle, 1'b1);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(negedge clk);

    // Quantize/pack and single-cycle output latency
    tick(1, 0, 0, 32'h0000_8000);
    tick(1, 0, 0, 32'h0001_0000);
    tick(1, 0, 0, 32'h0000_0000);
    tick(1, 0, 0, 32'h0000_4000);
    repeat (3) tick(0, 0, 0, 32'h0);
    check_val("lat_before", out_valid, 1'b0);
    tick(0, 0, 0, 32'h0);
    check_val("lat_valid", out_valid, 1'b1);
    check_val("pack_data", out_data, 32'h4000_FF80);
    check_val("pack_last", out_last, 1'b0);
    tick(0, 0, 1, 32'h0);

    // Rounding boundaries
    tick(1, 0, 0, 32'h0000_0080);
    tick(1, 0, 0, 32'h0000_007F);
    tick(1, 0, 0, 32'h0000_FF80);
    tick(1, 0, 0, 32'h0002_0000);
    wait_valid(10);
    check_val("round_data", out_data, 32'hFFFF_0001);
    tick(0, 0, 1, 32'h0);

    // Partial flush
    tick(1, 0, 0, 32'h0000_8000);
    tick(1, 0, 0, 32'h0000_4000);
    tick(0, 1, 0, 32'h0);
    check_val("flush_blocks_issue", issue_ready, 1'b0);
    wait_valid(20);
    check_val("flush_data", out_data, 32'h0000_4080);
    check_val("flush_last", out_last, 1'b1);
    tick(0, 0, 1, 32'h0);
    tick(0, 1, 0, 32'h0);
    repeat (3) tick(0, 0, 0, 32'h0);
    check_val("empty_flush_idle", idle, 1'b1);
    check_val("empty_flush_novalid", out_valid, 1'b0);

    // Back-pressure: credits cap acceptance at DEPTH*LANES
    dut_acc = 0;
    repeat (30) tick(1, 0, 0, gen_val());
    check_val("bp_accepted", dut_acc, DEPTH * LANES);
    check_val("bp_ready_low", issue_ready, 1'b0);
    repeat (8) tick(0, 0, 1, 32'h0);
    check_val("bp_ready_back", issue_ready, 1'b1);
    check_val("bp_idle", idle, 1'b1);

    // Full FIFO drained while issue continues
    repeat (22) tick(1, 0, 0, gen_val());
    repeat (40) tick(1, 0, 1, gen_val());
    repeat (12) tick(0, 0, 1, 32'h0);

    // Random traffic
    repeat (500) tick($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0, gen_val());

    // Asynchronous reset mid-stream, away from any clock edge
    #2 reset = 1'b0;
    #1;
    check_val("arst_out_valid", out_valid, 1'b0);
    check_val("arst_idle", idle, 1'b1);
    check_val("arst_issue_ready", issue_ready, 1'b1);
    model_clear();
    issue_valid = 0; flush = 0; out_ready = 0;
    @(posedge clk);
    @(posedge clk);
    #4 reset = 1'b1;
    @(negedge clk);
    tick(1, 0, 0, 32'h0001_0000);
    tick(0, 1, 0, 32'h0);
    wait_valid(20);
    check_val("post_rst_data", out_data, 32'h0000_00FF);
    check_val("post_rst_last", out_last, 1'b1);
    tick(0, 0, 1, 32'h0);

    repeat (150) tick($urandom_range(0, 1) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 1) != 0, gen_val());
    tick(0, 1, 1, 32'h0);
    repeat (30) tick(0, 0, 1, 32'h0);
    check_val("final_idle", idle, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sigmoid_out_packer.md
Name: sigmoid_out_packer

Overview:
Downstream stage of the SIMD fixed-point sigmoid unit. It tracks element validity through the sigmoid's fixed-latency, non-stallable pipeline. It quantizes each Q16.16 activation result in [0,1] to an unsigned 8-bit code and packs LANES codes per output word. Packed words are buffered in a small FIFO and drained through a valid/ready handshake. Because the sigmoid cannot stall, a credit check (issue_ready) back-pressures the issue side.

Parameters:
BIT_WIDTH, 32, width of the sigmoid result word (Q format)
DECIMAL_WIDTH, 16, fractional bits of the sigmoid result
SIG_LATENCY, 4, cycles from a value on the sigmoid input to its result on the sigmoid output
LANES, 4, 8-bit codes packed per output word (output width = 8*LANES)
FIFO_DEPTH, 4, packed-word FIFO entries (power of two, >=2)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
issue_valid  input  1  element presented to the sigmoid input this cycle
issue_ready  output  1  packer can accept the result of an element issued this cycle
flush  input  1  pulse: emit the partial word once all in-flight elements have landed
act_in  input  BIT_WIDTH  sigmoid output (combinational out of the sigmoid stage)
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head
out_data  output  8*LANES  packed codes; lane 0 in [7:0], lane k in [8k+7:8k]
out_last  output  1  word was closed by a flush (may be partial)
idle  output  1  no in-flight elements, pack register empty, FIFO empty, no flush pending

Behaviour:
- Reset (reset=0): out_valid=0, out_last=0, out_data=0, issue_ready=1, idle=1; valid delay line, pack register, lane counter, FIFO pointers and flush-pending all cleared. Reset mid-operation discards all in-flight and buffered data.
- Valid tracking: shift register of SIG_LATENCY bits. Bit 0 loads (issue_valid & issue_ready); bit SIG_LATENCY-1 is land_valid, which qualifies act_in. Elements issued while issue_ready=0 are dropped and never land.
- Quantize act_in (unsigned interpretation, bit BIT_WIDTH-1 assumed 0):
  - any bit at or above DECIMAL_WIDTH set -> 0xFF;
  - else code = act_in[DECIMAL_WIDTH-1:DECIMAL_WIDTH-8] + act_in[DECIMAL_WIDTH-9] (round half up), saturated at 0xFF.
- Packing: on land_valid, write the code into lane lane_cnt and increment lane_cnt. When lane_cnt reaches LANES-1, the word (including this code) is pushed to the FIFO with last=0 and lane_cnt wraps to 0. Unwritten lanes of any word read as 0.
- Credit rule:
  - free = (FIFO_DEPTH - fifo_count)*LANES - lane_cnt - inflight;
  - inflight = popcount of the delay line;
  - issue_ready = (free >= 1) & ~flush_pending. This is computed combinationally from registered state, so a landing element can never find the FIFO full.
- Flush: a flush pulse sets flush_pending. flush_pending does not block the lane landing in the same cycle.
  - When inflight==0 and lane_cnt>0: push the partial word with last=1 and clear lane_cnt and flush_pending.
  - When inflight==0 and lane_cnt==0: clear flush_pending and push nothing.
  - flush while flush_pending=1: no additional effect.
- FIFO: registered head. out_data/out_last/out_valid come straight from the head entry. A pop occurs on out_valid & out_ready. Simultaneous push and pop in the same cycle is allowed at any occupancy, including full.
- Latency: last code lands -> out_valid on the next cycle when the FIFO was empty.
- out_valid, once high, holds with stable out_data and out_last until accepted.

Optional Feature:
SIGMOID_PACK_SAT_COUNT_EN:
- Defined: adds output sat_count [15:0]. It increments on each landed element whose act_in had an integer bit set or whose rounding saturated. It saturates at 0xFFFF and clears on reset.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Quantize/pack: land 0x00008000, 0x00010000, 0x00000000, 0x00004000 -> one word out_data=0x4000FF80, out_last=0, out_valid exactly 1 cycle after the 4th land.
- Rounding: act_in 0x00000080 -> code 0x01; 0x0000007F -> 0x00; 0x0000FF80 -> 0xFF (saturated); 0x00020000 -> 0xFF.
- Back-pressure: out_ready=0 with continuous issue_valid and LANES=4, FIFO_DEPTH=4 -> exactly 16 elements accepted, issue_ready falls and stays 0, no overflow. Raising out_ready drains 4 words in order and issue_ready returns to 1.
- Flush: issue 2 elements then flush in the next cycle -> issue_ready=0 until landed, then out_data=0x0000xxyy with out_last=1. flush with nothing pending -> no word, idle returns to 1.
- Simultaneous push/pop with FIFO full and out_ready=1 -> count stays 4, no data loss, word order preserved.
- Async reset asserted mid-stream (not clock-aligned) -> out_valid=0 and idle=1 immediately. After release, the first new word contains no stale lanes.
